sub_int32_bs: RTL and testbench



---
 rtl/sub_bs_pkg.sv | 17 +
 rtl/full_sub_cell.sv | 15 +
 rtl/sub_int32_bs.sv | 113 +++++++++++
 tb/tb_sub_int32_bs.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sub_bs_pkg.sv
// Shared definitions for the bit-serial subtractor family: FSM states,
// default operand width and the full-subtractor borrow equation.
package sub_bs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;

  function automatic logic borrow_fn(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_sub_cell
  import sub_bs_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = borrow_fn(x, y, bin);

endmodule

// File: rtl/sub_int32_bs.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one bit per clock.
// Define SUB_INT32_BS_OVF_EN to add the registered signed-overflow output ovf.
module sub_int32_bs
  import sub_bs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
`ifdef SUB_INT32_BS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               d_bit, bout_bit;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b;
          res_sh <= '0;
          cnt    <= CNT_W'(WIDTH - 1);
          borrow <= 1'b0;
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          cnt    <= cnt - CNT_W'(1);
          borrow <= bout_bit;
        end
        default: ;
      endcase
    end
  end

  assign result     = res_sh;
  assign borrow_out = borrow;

`ifdef SUB_INT32_BS_OVF_EN
  // On the last RUN edge a_sh[0] is the original minuend MSB and d_bit is
  // the result MSB, so only the operand sign difference needs capturing.
  logic sign_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_diff <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign_diff <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (state == RUN && cnt == '0) begin
      ovf <= sign_diff & (a_sh[0] ^ d_bit);
    end
  end
`endif

endmodule

// File: tb/tb_sub_int32_bs.sv
// Directed self-checking bench for sub_int32_bs (optionally with SUB_INT32_BS_OVF_EN).
module tb_sub_int32_bs;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        borrow_out;
`ifdef SUB_INT32_BS_OVF_EN
  logic        ovf;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  sub_int32_bs #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .borrow_out (borrow_out)
`ifdef SUB_INT32_BS_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] exp_r, input logic exp_b,
                        input int unsigned hold, input int unsigned gap);
    int unsigned lat;
`ifdef SUB_INT32_BS_OVF_EN
    logic exp_o;
    exp_o = (ta[31] ^ tb_v[31]) & (ta[31] ^ exp_r[31]);
`endif
    repeat (gap) @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb_v;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd32);
    check("result", {32'd0, result}, {32'd0, exp_r});
    check("borrow", {63'd0, borrow_out}, {63'd0, exp_b});
`ifdef SUB_INT32_BS_OVF_EN
    check("ovf", {63'd0, ovf}, {63'd0, exp_o});
`endif
    for (int i = 0; i < int'(hold); i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_ready", {63'd0, in_ready}, 64'd0);
      check("hold_result", {32'd0, result}, {32'd0, exp_r});
      check("hold_borrow", {63'd0, borrow_out}, {63'd0, exp_b});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd0);
    check("release_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_borrow", {63'd0, borrow_out}, 64'd0);
`ifdef SUB_INT32_BS_OVF_EN
    check("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd5,          32'd3,          32'h0000_0002, 1'b0, 0, 0);
    run_op(32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1, 0, 1);
    run_op(32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 0, 0);
    run_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 0, 0);
    run_op(32'h1234_5678,  32'h1234_5678,  32'h0000_0000, 1'b0, 5, 0);
    run_op(32'h0000_0001,  32'h8000_0000,  32'h8000_0001, 1'b1, 0, 2);

    // Asynchronous reset after 10 RUN edges drops the operation.
    a = 32'h0000_FFFF;
    b = 32'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd100, 32'd200, 32'hFFFF_FF9C, 1'b1, 0, 0);

    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 17 == 0) rb = ra;
      if (n % 23 == 0) ra = 32'd0;
      run_op(ra, rb, ra - rb, (ra < rb), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
